// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller between one CPU requester and
// word-wide main memory; owns the tag/valid/dirty/data arrays and the lookup/WB/fill sequencing.
//
// state   | meaning
// IDLE    | waiting for cpu_req, latches the request
// LOOKUP  | tag compare; hit completes, miss picks WB or FILL
// WB      | writing the dirty victim line back word by word
// FILL    | reading the requested line word by word
// RESP    | one-cycle cpu_ready pulse
module cache_ctrl #(
   parameter int INDEX_BITS = 4,
   parameter int WORD_BITS  = 2,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cpu_req,
   input  logic             cpu_wr,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_ready,
   output logic             mem_req,
   output logic             mem_wr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << WORD_BITS;
   localparam int TAG_BITS = 32 - INDEX_BITS - WORD_BITS - 2;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [WORD_BITS-1:0]    cnt_q, cnt_d;
   logic [31:2]             addr_q;
   logic                    wr_q;
   logic [31:0]             wdata_q;
   logic                    replay_q;
   logic [LINES-1:0]        valid_q;
   logic [LINES-1:0]        dirty_q;
   logic [TAG_BITS-1:0]     tag_q  [LINES];
   logic [31:0]             data_q [LINES*WORDS];
   logic [31:0]             rdata_q;
   logic [CNT_W-1:0]        hit_q;
   logic [CNT_W-1:0]        miss_q;

   logic [WORD_BITS-1:0]    req_off;
   logic [INDEX_BITS-1:0]   req_idx;
   logic [TAG_BITS-1:0]     req_tag;
   logic                    hit;
   logic                    last_ack;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[1:0];

   assign req_off  = addr_q[WORD_BITS+1:2];
   assign req_idx  = addr_q[INDEX_BITS+WORD_BITS+1:WORD_BITS+2];
   assign req_tag  = addr_q[31:INDEX_BITS+WORD_BITS+2];
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign last_ack = mem_ack && (cnt_q == {WORD_BITS{1'b1}});

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         replay_q <= 1'b0;
         valid_q  <= '0;
         dirty_q  <= '0;
         rdata_q  <= '0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         case (state_q)
            S_IDLE: begin
               if (cpu_req) begin
                  addr_q  <= cpu_addr[31:2];
                  wr_q    <= cpu_wr;
                  wdata_q <= cpu_wdata;
               end
            end
            S_LOOKUP: begin
               replay_q <= 1'b0;
               if (hit) begin
                  if (wr_q) dirty_q[req_idx] <= 1'b1;
                  else      rdata_q <= data_q[{req_idx, req_off}];
                  if (!replay_q && hit_q != {CNT_W{1'b1}}) hit_q <= hit_q + 1'b1;
               end else begin
                  // Line is invalid while it is being replaced, so a partial fill never hits.
                  valid_q[req_idx] <= 1'b0;
                  if (!replay_q && miss_q != {CNT_W{1'b1}}) miss_q <= miss_q + 1'b1;
               end
            end
            S_WB: begin
               if (last_ack) dirty_q[req_idx] <= 1'b0;
            end
            S_FILL: begin
               if (last_ack) begin
                  valid_q[req_idx] <= 1'b1;
                  dirty_q[req_idx] <= 1'b0;
                  replay_q         <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage arrays have no reset; only the valid bits qualify them.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state_q == S_LOOKUP && hit && wr_q)
            data_q[{req_idx, req_off}] <= wdata_q;
         if (state_q == S_FILL && mem_ack)
            data_q[{req_idx, cnt_q}] <= mem_rdata;
         if (state_q == S_FILL && last_ack)
            tag_q[req_idx] <= req_tag;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:   if (cpu_req) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (hit)                                      state_d = S_RESP;
            else if (valid_q[req_idx] && dirty_q[req_idx]) state_d = S_WB;
            else                                          state_d = S_FILL;
         end
         S_WB: begin
            if (mem_ack) cnt_d = cnt_q + 1'b1;
            if (last_ack) state_d = S_FILL;
         end
         S_FILL: begin
            if (mem_ack) cnt_d = cnt_q + 1'b1;
            if (last_ack) state_d = S_LOOKUP;
         end
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cpu_ready = (state_q == S_RESP);
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_WB: begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
            mem_wdata = data_q[{req_idx, cnt_q}];
         end
         S_FILL: begin
            mem_req   = 1'b1;
            mem_addr  = {req_tag, req_idx, cnt_q, 2'b00};
         end
         default: ;
      endcase
   end

   assign cpu_rdata  = rdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: table of CPU accesses with hand-computed bursts and data,
// plus sequences for reset mid-fill and slow memory acknowledges.
module tb_cache_ctrl;
   logic        CLK = 1'b0;
   logic        RST;
   logic        cpu_req, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready;
   logic        mem_req, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic [15:0] hit_count, miss_count;

   cache_ctrl dut (
      .CLK(CLK), .RST(RST),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory model: untouched words read as 0xC0DE0000 ^ address
   logic [31:0] mem_m [logic [31:0]];
   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return 32'hC0DE_0000 ^ a;
   endfunction

   logic        log_wr   [$];
   logic [31:0] log_addr [$];
   logic [31:0] log_wd   [$];
   int          ack_delay = 0;
   bit          chk_stable = 0;

   initial begin
      int          wait_cnt;
      logic [31:0] snap_addr, snap_wd;
      logic        snap_wr;
      wait_cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      snap_addr = '0; snap_wd = '0; snap_wr = 1'b0;
      forever begin
         @(negedge CLK);
         if (mem_ack) mem_ack = 1'b0;
         else if (mem_req) begin
            if (wait_cnt == 0) begin
               snap_addr = mem_addr; snap_wd = mem_wdata; snap_wr = mem_wr;
            end else if (chk_stable) begin
               check("stall_mem_addr", mem_addr, snap_addr);
               check("stall_mem_wdata", mem_wdata, snap_wd);
               check("stall_mem_wr", {31'd0, mem_wr}, {31'd0, snap_wr});
            end
            if (chk_stable) check("stall_cpu_ready", {31'd0, cpu_ready}, 32'd0);
            if (wait_cnt < ack_delay) wait_cnt++;
            else begin
               wait_cnt = 0;
               log_wr.push_back(mem_wr);
               log_addr.push_back(mem_addr);
               log_wd.push_back(mem_wdata);
               if (mem_wr) mem_m[mem_addr] = mem_wdata;
               else        mem_rdata = mem_read(mem_addr);
               mem_ack = 1'b1;
            end
         end else wait_cnt = 0;
      end
   end

   task automatic clear_log();
      log_wr.delete(); log_addr.delete(); log_wd.delete();
   endtask

   task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int cycles);
      cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
      cycles = 0;
      do begin
         @(negedge CLK);
         cycles++;
      end while (!cpu_ready && cycles < 400);
      if (!cpu_ready) check("ready_timeout", {31'd0, cpu_ready}, 32'd1);
      rd = cpu_rdata;
      cpu_req = 1'b0;
   endtask

   task automatic check_burst(input int nwb, input logic [31:0] wb_base,
                              input int nfill, input logic [31:0] fill_base);
      check("burst_len", log_addr.size(), nwb + nfill);
      for (int i = 0; i < log_addr.size() && i < nwb + nfill; i++) begin
         if (i < nwb) begin
            check("wb_is_write", {31'd0, log_wr[i]}, 32'd1);
            check("wb_addr", log_addr[i], wb_base + 32'(4 * i));
         end else begin
            check("fill_is_read", {31'd0, log_wr[i]}, 32'd0);
            check("fill_addr", log_addr[i], fill_base + 32'(4 * (i - nwb)));
         end
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_hit;
      int          nwb;
      logic [31:0] wb_base;
      logic [31:0] wb_wd0;
      int          nfill;
      logic [31:0] fill_base;
      int          hits;
      int          misses;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [31:0] rd;
      int          cyc;
      int          n;

      vecs[0] = '{1'b0, 32'h0000_0000, 32'h0, 32'hC0DE_0000, 1'b0, 0, 32'h0, 32'h0, 4, 32'h0000_0000, 0, 1};
      vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, 32'hC0DE_0004, 1'b1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1};
      vecs[2] = '{1'b1, 32'h0004_0020, 32'h8888_8888, 32'h0, 1'b0, 0, 32'h0, 32'h0, 4, 32'h0004_0020, 1, 2};
      vecs[3] = '{1'b0, 32'h0004_0020, 32'h0, 32'h8888_8888, 1'b1, 0, 32'h0, 32'h0, 0, 32'h0, 2, 2};
      vecs[4] = '{1'b0, 32'h0000_0020, 32'h0, 32'hC0DE_0020, 1'b0, 4, 32'h0004_0020, 32'h8888_8888, 4, 32'h0000_0020, 2, 3};
      vecs[5] = '{1'b0, 32'h0004_0020, 32'h0, 32'h8888_8888, 1'b0, 0, 32'h0, 32'h0, 4, 32'h0004_0020, 2, 4};
      vecs[6] = '{1'b1, 32'h0000_000C, 32'h1234_5678, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 32'h0, 3, 4};
      vecs[7] = '{1'b0, 32'h1000_000C, 32'h0, 32'hD0DE_000C, 1'b0, 4, 32'h0000_0000, 32'hC0DE_0000, 4, 32'h1000_0000, 3, 5};
      vecs[8] = '{1'b0, 32'h0000_000C, 32'h0, 32'h1234_5678, 1'b0, 0, 32'h0, 32'h0, 4, 32'h0000_0000, 3, 6};

      RST = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(negedge CLK);
      check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_hit_count", {16'd0, hit_count}, 32'd0);
      check("rst_miss_count", {16'd0, miss_count}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 9; i++) begin
         clear_log();
         do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, cyc);
         if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         if (vecs[i].exp_hit) check($sformatf("v%0d_hit_latency", i), cyc, 32'd2);
         check_burst(vecs[i].nwb, vecs[i].wb_base, vecs[i].nfill, vecs[i].fill_base);
         if (vecs[i].nwb > 0 && log_wd.size() > 0)
            check($sformatf("v%0d_wb_word0", i), log_wd[0], vecs[i].wb_wd0);
         check($sformatf("v%0d_hit_count", i), {16'd0, hit_count}, vecs[i].hits);
         check($sformatf("v%0d_miss_count", i), {16'd0, miss_count}, vecs[i].misses);
         @(negedge CLK);
      end

      // Reset after two fill acks of line 8
      clear_log();
      ack_delay = 3;
      cpu_wr = 1'b0; cpu_addr = 32'h0000_0080; cpu_wdata = '0; cpu_req = 1'b1;
      n = 0;
      while (log_addr.size() < 2 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("rst_mid_two_acks", log_addr.size(), 32'd2);
      @(negedge CLK);
      RST = 1'b1; cpu_req = 1'b0;
      @(negedge CLK);
      check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mid_mem_addr", mem_addr, 32'd0);
      check("rst_mid_miss_count", {16'd0, miss_count}, 32'd0);
      check("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
      RST = 1'b0;
      ack_delay = 0;
      repeat (2) @(negedge CLK);
      check("rst_mid_no_more_acks", log_addr.size(), 32'd2);

      clear_log();
      do_access(1'b0, 32'h0000_0080, 32'h0, rd, cyc);
      check_burst(0, 32'h0, 4, 32'h0000_0080);
      check("refill_rdata", rd, 32'hC0DE_0080);
      check("refill_miss_count", {16'd0, miss_count}, 32'd1);
      check("refill_hit_count", {16'd0, hit_count}, 32'd0);
      @(negedge CLK);

      // Dirty line 0, then evict it with a slow memory
      clear_log();
      do_access(1'b1, 32'h0000_0104, 32'hABCD_0001, rd, cyc);
      check_burst(0, 32'h0, 4, 32'h0000_0100);
      @(negedge CLK);
      clear_log();
      ack_delay = 5;
      chk_stable = 1;
      do_access(1'b0, 32'h0000_0200, 32'h0, rd, cyc);
      chk_stable = 0;
      ack_delay = 0;
      check_burst(4, 32'h0000_0100, 4, 32'h0000_0200);
      if (log_wd.size() > 1) check("slow_wb_word1", log_wd[1], 32'hABCD_0001);
      check("slow_rdata", rd, 32'hC0DE_0200);
      check("slow_miss_count", {16'd0, miss_count}, 32'd3);
      check("slow_hit_count", {16'd0, hit_count}, 32'd0);
      @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
